// File: rtl/bitwise_frame_reducer.sv
// bitwise_frame_reducer: folds a frame of operand words with one bitwise
// operation (AND/OR/XOR/XNOR) chosen on the first word. It then presents one
// registered result word with the word count and the zero and parity flags.
// Both sides use a valid/ready handshake.
module bitwise_frame_reducer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_Data,
  input  logic [1:0]       i_Op,
  input  logic             i_Last,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Result,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Zero,
  output logic             o_Parity
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_XNOR = 2'b11} op_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             take;
  op_t              cur_op;
  logic [WIDTH-1:0] next_acc;
  logic [WIDTH-1:0] final_res;
  logic [CNT_W-1:0] next_cnt;

  // Handshake flags are decoded straight from the state register.
  assign o_Ready = (state != HOLD);
  assign o_Valid = (state == HOLD);
  assign take    = i_Valid & o_Ready;

  // Next accumulator/count values if the word on i_Data is accepted now.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_op    = op;
    next_acc  = acc;
    next_cnt  = cnt;
    final_res = acc;
    if (state == IDLE) begin
      // First word of a frame: the op is sampled here and the word seeds the fold.
      cur_op   = op_t'(i_Op);
      next_acc = i_Data;
      next_cnt = CNT_W'(1);
    end else begin
      unique case (op)
        OP_AND:  next_acc = acc & i_Data;
        OP_OR:   next_acc = acc | i_Data;
        default: next_acc = acc ^ i_Data;  // XNOR frames fold as XOR; invert once at the end
      endcase
      next_cnt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
    final_res = (cur_op == OP_XNOR) ? ~next_acc : next_acc;
  end

  // Frame FSM plus the accumulator and the registered result outputs.
  always_ff @(posedge i_Clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (i_Rst) begin
      state    <= IDLE;
      op       <= OP_AND;
      acc      <= '0;
      cnt      <= '0;
      o_Result <= '0;
      o_Count  <= '0;
      o_Zero   <= 1'b0;
      o_Parity <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (take) begin
            acc <= next_acc;
            op  <= cur_op;
            cnt <= next_cnt;
            if (i_Last) begin
              o_Result <= final_res;
              o_Count  <= next_cnt;
              o_Zero   <= ~|final_res;
              o_Parity <= ^final_res;
              state    <= HOLD;
            end else begin
              state    <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (i_Ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_frame_reducer.sv
// Directed self-checking bench for bitwise_frame_reducer.
// One instance uses the default widths. A second instance with CNT_W=2 shares
// the same stimulus and is used to check counter saturation.
module tb_bitwise_frame_reducer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_ready;

  logic             ready_a, valid_a, zero_a, parity_a;
  logic [WIDTH-1:0] result_a;
  logic [7:0]       count_a;

  logic             ready_b, valid_b, zero_b, parity_b;
  logic [WIDTH-1:0] result_b;
  logic [1:0]       count_b;

  int tests_run;
  int tests_failed;

  bitwise_frame_reducer #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(in_valid), .o_Ready(ready_a),
    .i_Data(in_data), .i_Op(in_op), .i_Last(in_last), .o_Valid(valid_a),
    .i_Ready(out_ready), .o_Result(result_a), .o_Count(count_a),
    .o_Zero(zero_a), .o_Parity(parity_a)
  );

  bitwise_frame_reducer #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(in_valid), .o_Ready(ready_b),
    .i_Data(in_data), .i_Op(in_op), .i_Last(in_last), .o_Valid(valid_b),
    .i_Ready(out_ready), .o_Result(result_b), .o_Count(count_b),
    .o_Zero(zero_b), .o_Parity(parity_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]       op;
    int               nwords;
    logic [WIDTH-1:0] w0;
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] exp_res;
    logic [7:0]       exp_cnt;
    logic             exp_zero;
    logic             exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] op, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] res,
                               input logic [7:0] cnt, input logic z, input logic p);
    check({tag, " valid"},  valid_a,  1);
    check({tag, " ready"},  ready_a,  0);
    check({tag, " result"}, result_a, res);
    check({tag, " count"},  count_a,  cnt);
    check({tag, " zero"},   zero_a,   z);
    check({tag, " parity"}, parity_a, p);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{2'b00, 2, 4'b0101, 4'b1100, 4'b0100, 8'd2, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 2, 4'b0101, 4'b1100, 4'b1101, 8'd2, 1'b0, 1'b1};
    vecs[2] = '{2'b10, 2, 4'b0101, 4'b1100, 4'b1001, 8'd2, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 2, 4'b0101, 4'b1100, 4'b0110, 8'd2, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 1, 4'b1010, 4'b0000, 4'b1010, 8'd1, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 1, 4'b1010, 4'b0000, 4'b0101, 8'd1, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 2, 4'b0001, 4'b0010, 4'b0000, 8'd2, 1'b1, 1'b0};

    // Reset held for two cycles.
    tick();
    tick();
    rst = 1'b0;
    check("reset valid",  valid_a,  0);
    check("reset ready",  ready_a,  1);
    check("reset result", result_a, 0);
    check("reset count",  count_a,  0);
    check("reset zero",   zero_a,   0);
    check("reset parity", parity_a, 0);

    // Table-driven frames. i_Ready is high, so the result is taken in one cycle.
    // The op on the second word is deliberately different, because it must be ignored.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].nwords == 2) begin
        send(vecs[i].w0, vecs[i].op, 1'b0);
        check($sformatf("vec%0d first-word valid", i), valid_a, 0);
        send(vecs[i].w1, ~vecs[i].op, 1'b1);
      end else begin
        send(vecs[i].w0, vecs[i].op, 1'b1);
      end
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_cnt,
                    vecs[i].exp_zero, vecs[i].exp_par);
      tick();
      check($sformatf("vec%0d release valid", i), valid_a, 0);
      check($sformatf("vec%0d release ready", i), ready_a, 1);
    end

    // Backpressure: the result is held for 5 cycles and new input is refused.
    out_ready = 1'b0;
    send(4'b0101, 2'b10, 1'b0);
    send(4'b1100, 2'b10, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 4'b1111;
      in_op    = 2'b01;
      in_last  = 1'b1;
      check_outputs($sformatf("stall%0d", c), 4'b1001, 8'd2, 1'b0, 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check_outputs("stall end", 4'b1001, 8'd2, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check("bp release valid", valid_a, 0);
    check("bp release ready", ready_a, 1);
    check("bp retained result", result_a, 4'b1001);
    send(4'b0011, 2'b01, 1'b1);
    check_outputs("bp next frame", 4'b0011, 8'd1, 1'b0, 1'b0);
    tick();

    // Gaps in the input: i_Op toggles and a stray i_Last arrives without a transfer.
    send(4'b1111, 2'b00, 1'b0);
    in_op = 2'b01;
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("gap1 valid", valid_a, 0);
    send(4'b0111, 2'b01, 1'b0);
    tick();
    check("gap2 valid", valid_a, 0);
    send(4'b0011, 2'b10, 1'b1);
    check_outputs("gaps", 4'b0011, 8'd3, 1'b0, 1'b0);
    tick();

    // Saturation: a 5-word OR frame. The 2-bit counter must stop at 3.
    send(4'b0001, 2'b01, 1'b0);
    send(4'b0010, 2'b00, 1'b0);
    send(4'b0100, 2'b00, 1'b0);
    send(4'b1000, 2'b00, 1'b0);
    send(4'b0000, 2'b00, 1'b1);
    check_outputs("sat wide", 4'b1111, 8'd5, 1'b0, 1'b0);
    check("sat narrow valid",  valid_b,  1);
    check("sat narrow count",  count_b,  3);
    check("sat narrow result", result_b, 4'b1111);
    tick();

    // A reset in the middle of a frame discards that frame.
    send(4'b1000, 2'b01, 1'b0);
    send(4'b0100, 2'b01, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst valid",  valid_a,  0);
    check("midrst ready",  ready_a,  1);
    check("midrst result", result_a, 0);
    check("midrst count",  count_a,  0);
    tick();
    check("midrst no result", valid_a, 0);
    send(4'b0110, 2'b10, 1'b0);
    send(4'b0011, 2'b00, 1'b1);
    check_outputs("after reset", 4'b0101, 8'd2, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
